// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multi-cycle RISC-V core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// the instruction and data memories, and parks in a sticky TRAP state on an
// illegal opcode or a memory that never answers.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,   // max wait cycles on imem/dmem; 0 disables
    parameter bit SUPPORT_JAL = 1'b1  // 0: JAL decodes as illegal
) (
    input  logic       clk,
    input  logic       reset,         // synchronous, active-low
    input  logic [6:0] Opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       Branch,
    output logic       Jump,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       trap
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Counter only has to reach MEM_TIMEOUT-1: the trap fires on the cycle
    // that would make it MEM_TIMEOUT.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_SW, C_BR, C_LUI, C_JAL, C_ILL
    } cls_t;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
    } ctrl_t;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            OP_R:    classify = C_R;
            OP_I:    classify = C_I;
            OP_LW:   classify = C_LW;
            OP_SW:   classify = C_SW;
            OP_BR:   classify = C_BR;
            OP_LUI:  classify = C_LUI;
            OP_JAL:  classify = SUPPORT_JAL ? C_JAL : C_ILL;
            default: classify = C_ILL;
        endcase
    endfunction

    state_t           state, nxt;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    cls_t             cls_q, cls_live;
    logic             timeout;
    logic             alu_src_q;
    logic [1:0]       alu_op_q;
    ctrl_t            ctrl;

    assign cls_q    = classify(op_q);
    assign cls_live = classify(Opcode);
    assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(LIMIT));

    // State, latched opcode and wait counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == S_DECODE)
                op_q <= Opcode;
        end
    end

    // Next-state selection; a ready on the limit cycle beats the timeout.
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: begin
                if (imem_ready)   nxt = S_DECODE;
                else if (timeout) nxt = S_TRAP;
            end
            S_DECODE: nxt = (cls_live == C_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_BR:       nxt = S_FETCH;
                    C_LW, C_SW: nxt = S_MEM;
                    default:    nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready)   nxt = (cls_q == C_LW) ? S_WB : S_FETCH;
                else if (timeout) nxt = S_TRAP;
            end
            S_WB:    nxt = S_FETCH;
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase
    end

    // Wait counter counts only stalled FETCH/MEM cycles; any state change
    // (including entry to FETCH/MEM) leaves it at zero.
    always_comb begin
        wait_cnt_nxt = '0;
        if (((state == S_FETCH) && !imem_ready && (nxt == S_FETCH)) ||
            ((state == S_MEM)   && !dmem_ready && (nxt == S_MEM)))
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end

    // ALU operand/operation for the latched instruction class.
    always_comb begin
        alu_src_q = 1'b0;
        alu_op_q  = 2'b00;
        case (cls_q)
            C_R:        begin alu_src_q = 1'b0; alu_op_q = 2'b10; end
            C_I:        begin alu_src_q = 1'b1; alu_op_q = 2'b10; end
            C_LW, C_SW: begin alu_src_q = 1'b1; alu_op_q = 2'b00; end
            C_BR:       begin alu_src_q = 1'b0; alu_op_q = 2'b01; end
            C_LUI:      begin alu_src_q = 1'b1; alu_op_q = 2'b11; end
            C_JAL:      begin alu_src_q = 1'b1; alu_op_q = 2'b00; end
            default:    begin alu_src_q = 1'b0; alu_op_q = 2'b00; end
        endcase
    end

    // Datapath strobes per state, from the latched opcode only.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.imem_req = 1'b1;
                ctrl.ir_write = imem_ready;
                ctrl.pc_write = imem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src = alu_src_q;
                ctrl.alu_op  = alu_op_q;
                ctrl.branch  = (cls_q == C_BR);
                ctrl.jump    = (cls_q == C_JAL);
            end
            S_MEM: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = 2'b00;
                ctrl.mem_read  = (cls_q == C_LW);
                ctrl.mem_write = (cls_q == C_SW);
            end
            S_WB: begin
                ctrl.alu_src    = alu_src_q;
                ctrl.alu_op     = alu_op_q;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (cls_q == C_LW);
            end
            S_TRAP:  ctrl.trap = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // Reset silences every strobe at once, even mid-instruction.
    ctrl_t ctrl_o;
    assign ctrl_o = reset ? ctrl : '0;

    assign imem_req = ctrl_o.imem_req;
    assign IRWrite  = ctrl_o.ir_write;
    assign PCWrite  = ctrl_o.pc_write;
    assign ALUSrc   = ctrl_o.alu_src;
    assign ALUOp    = ctrl_o.alu_op;
    assign Branch   = ctrl_o.branch;
    assign Jump     = ctrl_o.jump;
    assign MemRead  = ctrl_o.mem_read;
    assign MemWrite = ctrl_o.mem_write;
    assign MemtoReg = ctrl_o.mem_to_reg;
    assign RegWrite = ctrl_o.reg_write;
    assign trap     = ctrl_o.trap;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each
// issued instruction (opcode, fetch/mem wait states) into its per-cycle
// strobe trace and queues it; a negedge monitor compares the DUT against it.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [6:0] opc = '0;
    logic       iready = 1'b0, dready = 1'b0;

    // dut a: MEM_TIMEOUT=16, JAL legal; dut b: MEM_TIMEOUT=4, JAL illegal
    logic a_ireq, a_irw, a_pcw, a_asrc, a_br, a_jmp, a_mr, a_mw, a_m2r, a_rw, a_trap;
    logic b_ireq, b_irw, b_pcw, b_asrc, b_br, b_jmp, b_mr, b_mw, b_m2r, b_rw, b_trap;
    logic [1:0] a_aop, b_aop;
    logic [12:0] act_a, act_b;

    multicycle_controller #(.MEM_TIMEOUT(16), .SUPPORT_JAL(1'b1)) u_a (
        .clk(clk), .reset(rst_a), .Opcode(opc), .imem_ready(iready), .dmem_ready(dready),
        .imem_req(a_ireq), .IRWrite(a_irw), .PCWrite(a_pcw), .ALUSrc(a_asrc), .ALUOp(a_aop),
        .Branch(a_br), .Jump(a_jmp), .MemRead(a_mr), .MemWrite(a_mw), .MemtoReg(a_m2r),
        .RegWrite(a_rw), .trap(a_trap));

    multicycle_controller #(.MEM_TIMEOUT(4), .SUPPORT_JAL(1'b0)) u_b (
        .clk(clk), .reset(rst_b), .Opcode(opc), .imem_ready(iready), .dmem_ready(dready),
        .imem_req(b_ireq), .IRWrite(b_irw), .PCWrite(b_pcw), .ALUSrc(b_asrc), .ALUOp(b_aop),
        .Branch(b_br), .Jump(b_jmp), .MemRead(b_mr), .MemWrite(b_mw), .MemtoReg(b_m2r),
        .RegWrite(b_rw), .trap(b_trap));

    assign act_a = {a_ireq, a_irw, a_pcw, a_asrc, a_aop, a_br, a_jmp, a_mr, a_mw, a_m2r, a_rw, a_trap};
    assign act_b = {b_ireq, b_irw, b_pcw, b_asrc, b_aop, b_br, b_jmp, b_mr, b_mw, b_m2r, b_rw, b_trap};

    // Scoreboard: bit 13 selects which DUT the expectation belongs to.
    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    int    sel     = 0;    // active DUT
    int    tmo     = 16;   // its MEM_TIMEOUT
    bit    jal_ok  = 1'b1; // its SUPPORT_JAL
    bit    trapped = 1'b0;
    string tag     = "reset";

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [13:0] e;
        logic [12:0] act;
        string       t;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = e[13] ? act_b : act_a;
            checks++;
            if (act !== e[12:0]) begin
                errors++;
                $display("FAIL %s dut=%0d cyc=%0d got=%b want=%b (ireq irw pcw asrc aop br jmp mr mw m2r rw trap)",
                         t, e[13], cyc, act, e[12:0]);
            end
        end
    end

    function automatic logic [12:0] pack(input bit ireq, input bit irw, input bit pcw,
                                         input bit asrc, input logic [1:0] aop,
                                         input bit br, input bit jmp, input bit mr,
                                         input bit mw, input bit m2r, input bit rw, input bit tr);
        return {ireq, irw, pcw, asrc, aop, br, jmp, mr, mw, m2r, rw, tr};
    endfunction

    // Instruction class: 0 R,1 I,2 LW,3 SW,4 BR,5 LUI,6 JAL,7 illegal
    function automatic int cls_of(input logic [6:0] op, input bit jal);
        case (op)
            OP_R:    return 0;
            OP_I:    return 1;
            OP_LW:   return 2;
            OP_SW:   return 3;
            OP_BR:   return 4;
            OP_LUI:  return 5;
            OP_JAL:  return jal ? 6 : 7;
            default: return 7;
        endcase
    endfunction

    // {ALUSrc, ALUOp} for a class, straight from the opcode table.
    function automatic logic [2:0] alu_of(input int c);
        case (c)
            0:       return 3'b0_10;
            1:       return 3'b1_10;
            2, 3:    return 3'b1_00;
            4:       return 3'b0_01;
            5:       return 3'b1_11;
            6:       return 3'b1_00;
            default: return 3'b0_00;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    task automatic step(input logic rst, input logic ir, input logic dr,
                        input logic [6:0] op, input logic [12:0] e);
        if (sel == 0) begin rst_a = rst; rst_b = 1'b0; end
        else          begin rst_b = rst; rst_a = 1'b0; end
        iready = ir;
        dready = dr;
        opc    = op;
        exp_q.push_back({sel[0], e});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rb(), rb(), ro(), 13'd0);
        trapped = 1'b0;
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, rb(), rb(), ro(), pack(0,0,0,0,2'b00,0,0,0,0,0,0,1));
    endtask

    // One instruction: fw stalled fetch cycles, mw stalled mem cycles.
    // abort>0 stops issuing after that many cycles (mid-instruction reset).
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int abort);
        int         n = 0;
        int         c;
        logic [2:0] a;
        c = cls_of(op, jal_ok);
        a = alu_of(c);
        for (int k = 0; k <= fw; k++) begin
            if (abort > 0 && n >= abort) return;
            if (tmo != 0 && k == tmo) begin trapped = 1'b1; return; end
            if (k == fw) step(1'b1, 1'b1, rb(), ro(), pack(1,1,1,0,2'b00,0,0,0,0,0,0,0));
            else         step(1'b1, 1'b0, rb(), ro(), pack(1,0,0,0,2'b00,0,0,0,0,0,0,0));
            n++;
        end
        if (abort > 0 && n >= abort) return;
        step(1'b1, rb(), rb(), op, 13'd0);
        n++;
        if (c == 7) begin trapped = 1'b1; return; end
        if (abort > 0 && n >= abort) return;
        step(1'b1, rb(), rb(), ro(),
             pack(0,0,0,a[2],a[1:0], c == 4, c == 6, 0,0,0,0,0));
        n++;
        if (c == 4) return;
        if (c == 2 || c == 3) begin
            for (int k = 0; k <= mw; k++) begin
                if (abort > 0 && n >= abort) return;
                if (tmo != 0 && k == tmo) begin trapped = 1'b1; return; end
                step(1'b1, rb(), (k == mw), ro(),
                     pack(0,0,0,1,2'b00,0,0, c == 2, c == 3, 0,0,0));
                n++;
            end
            if (c == 3) return;
        end
        if (abort > 0 && n >= abort) return;
        step(1'b1, rb(), rb(), ro(), pack(0,0,0,a[2],a[1:0],0,0,0,0, c == 2, 1, 0));
    endtask

    task automatic random_run(input int count, input int maxw);
        logic [6:0] legal [7];
        logic [6:0] op;
        legal = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI, OP_JAL};
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 99) < 88) op = legal[$urandom_range(0, 6)];
            else                            op = ro();
            run_instr(op, $urandom_range(0, maxw), $urandom_range(0, maxw), 0);
            if (trapped) begin
                trap_cycles(2);
                do_reset(1);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // dut a
        sel = 0; tmo = 16; jal_ok = 1'b1;
        tag = "reset";      do_reset(3);
        checks++;
        if (act_a !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got=%b want=0", act_a);
        end
        tag = "r_type";     run_instr(OP_R, 0, 0, 0);
        tag = "lw_wait5";   run_instr(OP_LW, 0, 5, 0);
        tag = "i_type";     run_instr(OP_I, 2, 0, 0);
        tag = "sw";         run_instr(OP_SW, 1, 2, 0);
        tag = "branch";     run_instr(OP_BR, 0, 0, 0);
        tag = "lui";        run_instr(OP_LUI, 0, 0, 0);
        tag = "jal";        run_instr(OP_JAL, 3, 0, 0);
        tag = "sw_abort";   run_instr(OP_SW, 0, 10, 5);
        tag = "mid_reset";  do_reset(1);
        tag = "after_rst";  run_instr(OP_R, 0, 0, 0);
        tag = "illegal";    run_instr(7'b1111111, 0, 0, 0);
        tag = "trap_stick"; trap_cycles(5);
        tag = "reset";      do_reset(2);
        tag = "rand_a";     random_run(150, 3);

        // dut b
        sel = 1; tmo = 4; jal_ok = 1'b0;
        tag = "reset_b";    do_reset(3);
        tag = "jal_off";    run_instr(OP_JAL, 0, 0, 0);
        tag = "trap_stick"; trap_cycles(4);
        tag = "reset_b";    do_reset(1);
        tag = "imem_tmo";   run_instr(OP_R, 6, 0, 0);
        checks++;
        if (b_trap !== 1'b1) begin
            errors++;
            $display("FAIL expired_wait trap=%b want=1", b_trap);
        end
        tag = "trap_stick"; trap_cycles(3);
        tag = "reset_b";    do_reset(1);
        tag = "ready_lim";  run_instr(OP_R, 3, 0, 0);
        tag = "dmem_lim";   run_instr(OP_SW, 0, 3, 0);
        tag = "dmem_tmo";   run_instr(OP_LW, 0, 4, 0);
        tag = "trap_stick"; trap_cycles(3);
        tag = "reset_b";    do_reset(1);
        tag = "rand_b";     random_run(150, 5);

        if (exp_q.size() != 0) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
